// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_unit_pkg: shared opcodes, fetch state and widths        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package instr_fetch_unit_pkg;

  localparam int INST_W = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_next_pc_calc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_unit_next_pc_calc: sequential/branch/jump/jr targets    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module instr_fetch_unit_next_pc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [INST_W-1:0] pc_i,
  input  logic [INST_W-1:0] id_pc_plus4_i,
  input  logic [15:0]       br_offset_i,
  input  logic [25:0]       jmp_index_i,
  input  logic [INST_W-1:0] jr_target_i,
  output logic [INST_W-1:0] seq_pc_o,
  output logic [INST_W-1:0] br_pc_o,
  output logic [INST_W-1:0] jmp_pc_o,
  output logic [INST_W-1:0] jr_pc_o
);

  assign seq_pc_o = pc_i + 32'd4;
  // Branch offset counts words relative to the instruction after the branch.
  assign br_pc_o  = id_pc_plus4_i + {{14{br_offset_i[15]}}, br_offset_i, 2'b00};
  assign jmp_pc_o = {id_pc_plus4_i[31:28], jmp_index_i, 2'b00};
  assign jr_pc_o  = jr_target_i;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_unit: PC owner, imem read initiator and IF/ID register  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_BYTES = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_BYTES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  idpc_q, idpc_d;
  logic [31:0]  idpc4_q, idpc4_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic         fault_q, fault_d;

  logic [31:0]  seq_pc, br_pc, jmp_pc, jr_pc, redir_pc;
  logic         redirect;

  instr_fetch_unit_next_pc_calc u_next_pc (
    .pc_i          (pc_q),
    .id_pc_plus4_i (idpc4_q),
    .br_offset_i   (br_offset),
    .jmp_index_i   (jmp_index),
    .jr_target_i   (jr_target),
    .seq_pc_o      (seq_pc),
    .br_pc_o       (br_pc),
    .jmp_pc_o      (jmp_pc),
    .jr_pc_o       (jr_pc)
  );

  // Redirects are only meaningful while a real instruction sits in ID.
  assign redirect = valid_q & (jr | jmp | br_taken);
  assign redir_pc = jr ? jr_pc : (jmp ? jmp_pc : br_pc);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    idpc_d   = idpc_q;
    idpc4_d  = idpc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
      RUN: begin
        if (!stall) begin
          if (redirect) begin
            inst_d  = 32'd0;
            valid_d = 1'b0;
            if (jr && (jr_target[1:0] != 2'b00)) begin
              state_d = HALT;
              fault_d = 1'b1;
            end else if (redir_pc >= PC_LIMIT) begin
              state_d  = HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = redir_pc;
            end
          end else if (seq_pc >= PC_LIMIT) begin
            // Stop before presenting anything past the end of memory.
            state_d  = HALT;
            halted_d = 1'b1;
            inst_d   = 32'd0;
            valid_d  = 1'b0;
          end else begin
            inst_d  = imem_inst;
            idpc_d  = pc_q;
            idpc4_d = seq_pc;
            valid_d = 1'b1;
            pc_d    = seq_pc;
          end
        end
      end
      HALT: begin
        inst_d  = 32'd0;
        valid_d = 1'b0;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      inst_q   <= 32'd0;
      idpc_q   <= 32'd0;
      idpc4_q  <= 32'd4;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      idpc_q   <= idpc_d;
      idpc4_q  <= idpc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign imem_pc     = pc_q;
  assign id_inst     = inst_q;
  assign id_pc       = idpc_q;
  assign id_pc_plus4 = idpc4_q;
  assign id_valid    = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_fetch_unit: directed self-checking bench for fetch unit    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        stall, br_taken, jmp, jr;
  logic [15:0] br_offset;
  logic [25:0] jmp_index;
  logic [31:0] jr_target;
  logic [31:0] id_inst, id_pc, id_pc_plus4;
  logic        id_valid, halted, fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return (a == 32'd0) ? 32'h3C01FFFF : (32'hC0DE0000 | a);
  endfunction

  assign imem_inst = inst_at(imem_pc);

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_pc     (imem_pc),
    .imem_inst   (imem_inst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .jmp         (jmp),
    .jmp_index   (jmp_index),
    .jr          (jr),
    .jr_target   (jr_target),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid),
    .halted      (halted),
    .fault       (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the full IF/ID view for a valid instruction at pc p with fetch at f.
  task automatic chk_valid(input string tag, input logic [31:0] p, input logic [31:0] f);
    chk({tag, ".imem_pc"}, imem_pc, f);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, 32'd1);
    chk({tag, ".id_pc"}, id_pc, p);
    chk({tag, ".id_inst"}, id_inst, inst_at(p));
    chk({tag, ".id_pc_plus4"}, id_pc_plus4, p + 32'd4);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".imem_pc"}, imem_pc, 32'd0);
    chk({tag, ".id_inst"}, id_inst, 32'd0);
    chk({tag, ".id_pc"}, id_pc, 32'd0);
    chk({tag, ".id_pc_plus4"}, id_pc_plus4, 32'd4);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
    chk({tag, ".fault"}, {31'd0, fault}, 32'd0);
  endtask

  // Release reset, pass BOOT, and land on id_pc=0 with imem_pc=4.
  task automatic boot_and_first();
    rst_n = 1'b1;
    step();
    chk("boot.imem_pc", imem_pc, 32'd0);
    chk("boot.id_valid", {31'd0, id_valid}, 32'd0);
    step();
    chk_valid("first", 32'd0, 32'd4);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; jr = 1'b0;
    br_offset = 16'd0; jmp_index = 26'd0; jr_target = 32'd0;
    step();
    chk_reset("reset");

    boot_and_first();
    step();
    chk_valid("seq4", 32'd4, 32'd8);
    for (int i = 0; i < 9; i++) step();
    chk_valid("seq40", 32'd40, 32'd44);

    // Taken branch from id_pc=40, offset 2 words -> 44 + 8 = 52
    br_taken = 1'b1; br_offset = 16'd2;
    step();
    br_taken = 1'b0;
    chk("br.imem_pc", imem_pc, 32'd52);
    chk("br.bubble", {31'd0, id_valid}, 32'd0);
    chk("br.bubble_inst", id_inst, 32'd0);
    step();
    chk_valid("br.target", 32'd52, 32'd56);
    step();
    chk_valid("jal.in_id", 32'd56, 32'd60);

    jmp = 1'b1; jmp_index = 26'h12;
    step();
    jmp = 1'b0;
    chk("jmp.imem_pc", imem_pc, 32'd72);
    chk("jmp.bubble", {31'd0, id_valid}, 32'd0);
    step();
    chk_valid("jmp.target", 32'd72, 32'd76);

    jr = 1'b1; jr_target = 32'd60;
    step();
    jr = 1'b0;
    chk("jr.imem_pc", imem_pc, 32'd60);
    chk("jr.bubble", {31'd0, id_valid}, 32'd0);
    step();
    chk_valid("jr.target", 32'd60, 32'd64);

    // Stall with a pending branch (offset -1 -> 64 - 4 = 60)
    stall = 1'b1; br_taken = 1'b1; br_offset = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_valid("stall", 32'd60, 32'd64);
    end
    stall = 1'b0;
    step();
    br_taken = 1'b0;
    chk("stall.br_imem_pc", imem_pc, 32'd60);
    chk("stall.br_bubble", {31'd0, id_valid}, 32'd0);

    // Jump while ID holds a bubble must be ignored
    jmp = 1'b1; jmp_index = 26'h30;
    step();
    jmp = 1'b0;
    chk_valid("ign_redirect", 32'd60, 32'd64);

    for (int i = 0; i < 33; i++) step();
    chk_valid("seq192", 32'd192, 32'd196);
    step();
    chk("end.halted", {31'd0, halted}, 32'd1);
    chk("end.id_valid", {31'd0, id_valid}, 32'd0);
    chk("end.imem_pc", imem_pc, 32'd196);
    chk("end.fault", {31'd0, fault}, 32'd0);
    step();
    chk("end.halted_sticky", {31'd0, halted}, 32'd1);
    chk("end.imem_pc_frozen", imem_pc, 32'd196);
    chk("end.id_valid_hold", {31'd0, id_valid}, 32'd0);

    // Async reset out of HALT, between edges
    #3 rst_n = 1'b0;
    #1 chk_reset("async_halt");
    step();
    boot_and_first();
    step();
    chk_valid("re.seq4", 32'd4, 32'd8);

    jr = 1'b1; jr_target = 32'h2E;
    step();
    jr = 1'b0;
    chk("misalign.fault", {31'd0, fault}, 32'd1);
    chk("misalign.halted", {31'd0, halted}, 32'd0);
    chk("misalign.id_valid", {31'd0, id_valid}, 32'd0);
    chk("misalign.imem_pc", imem_pc, 32'd8);
    step();
    chk("misalign.sticky", {31'd0, fault}, 32'd1);
    chk("misalign.imem_pc_frozen", imem_pc, 32'd8);

    #3 rst_n = 1'b0;
    #1 chk_reset("async_fault");
    step();
    boot_and_first();
    step();
    step();
    chk_valid("mid.seq8", 32'd8, 32'd12);

    // Mid-run async reset: no edge needed for outputs to clear
    #3 rst_n = 1'b0;
    #1 chk_reset("async_mid");
    step();
    boot_and_first();

    // Jump target 0x100 lies beyond memory
    jmp = 1'b1; jmp_index = 26'h40;
    step();
    jmp = 1'b0;
    chk("oor_jmp.halted", {31'd0, halted}, 32'd1);
    chk("oor_jmp.imem_pc", imem_pc, 32'd4);
    chk("oor_jmp.id_valid", {31'd0, id_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the PC and drives the byte address into the instruction memory.
- Captures the returned word and presents it, with its PC, to decode through an IF/ID pipeline register.
- Applies stalls and control-flow redirects (bne/beq, j/jal, jr) resolved in decode. No branch delay slot.

Parameters:
- RESET_PC, 32'd0, PC loaded on reset.
- MEM_BYTES, 200, byte-address limit of instruction memory; any fetch PC >= MEM_BYTES is out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_pc  out  32  byte address to instruction memory; word-aligned. Memory read is combinational.
- imem_inst  in  32  word returned for imem_pc in the same cycle.
- stall  in  1  decode hazard; hold PC and IF/ID contents.
- br_taken  in  1  branch in ID is taken.
- br_offset  in  16  signed word offset of that branch.
- jmp  in  1  j/jal in ID.
- jmp_index  in  26  jump word index.
- jr  in  1  jr in ID.
- jr_target  in  32  register value for jr.
- id_inst  out  32  IF/ID instruction.
- id_pc  out  32  PC of id_inst.
- id_pc_plus4  out  32  id_pc+4; used as the jal link value.
- id_valid  out  1  id_inst is a real instruction (not a bubble).
- halted  out  1  fetch stopped on an out-of-range PC.
- fault  out  1  fetch stopped on a misaligned jr target.

Behaviour:
Reset (async, rst_n=0):
- pc=RESET_PC; id_inst=0, id_pc=0, id_pc_plus4=4, id_valid=0, halted=0, fault=0.
- State=BOOT. Reset mid-operation discards all in-flight state immediately.

States:
- BOOT: one cycle with id_valid=0, then RUN.
- RUN: normal fetch.
- HALT: terminal until reset. pc frozen; id_valid=0 every cycle.

Fetch:
- imem_pc=pc continuously.
- At each RUN edge, the IF/ID register captures imem_inst, pc and pc+4, and id_valid=1. Fetch-to-ID latency is 1 cycle.

Next-PC priority, evaluated only in RUN:
1. stall=1: pc and IF/ID hold. All redirect inputs are ignored; decode re-presents them once stall drops.
2. Redirect (at most one of br_taken/jmp/jr asserted; jr > jmp > br_taken if several):
   - branch: pc = id_pc_plus4 + (sext(br_offset) << 2), with 32-bit wrap.
   - jump: pc = {id_pc_plus4[31:28], jmp_index, 2'b00}.
   - jr: pc = jr_target.
   - IF/ID loads a bubble (id_valid=0, id_inst=0), flushing the wrong-path word. Redirect penalty is 1 cycle.
3. Otherwise: pc = pc+4, with 32-bit wrap.

Boundaries:
- A next-PC >= MEM_BYTES enters HALT and sets halted=1; the out-of-range word is never presented.
- A jr_target with [1:0] != 0 enters HALT and sets fault=1.
- A redirect asserted while id_valid=0 is ignored.
- halted and fault are sticky until reset.

Decomposition:
- Shared package: opcode/funct constants (J=6'h02, JAL=6'h03, BEQ=6'h04, BNE=6'h05, SPECIAL=6'h00 with JR funct 6'h08); fetch state enum {BOOT, RUN, HALT}; INST_W=32.
- One sub-module: next_pc_calc, combinational, computing the sequential, branch, jump and jr targets.

Test Plan:
1. Reset release with the reference program loaded, no stall -> imem_pc steps 0, 4, 8, ...; first id_valid=1 has id_pc=0, id_inst=32'h3C01FFFF.
2. id_pc=40 with br_taken=1, br_offset=2 -> next imem_pc=52; following cycle id_valid=0; then id_pc=52.
3. id_pc=56, jmp=1, jmp_index=26'h12 -> imem_pc=72, id_pc_plus4=60 while jal is in ID. Then jr=1, jr_target=60 -> imem_pc=60.
4. stall held 3 cycles with br_taken=1 also asserted -> imem_pc and id_* frozen for 3 cycles; the redirect takes effect only in the first cycle after stall drops.
5. Sequential fetch reaching pc=196 -> next PC 200 >= MEM_BYTES, so halted=1, id_valid=0, imem_pc frozen. jr_target=0x2E -> fault=1.
6. rst_n dropped mid-run, asynchronously between edges -> outputs return to reset values without waiting for a clock edge; after release the BOOT cycle repeats and fetch restarts at 0.
